// File: rtl/mnist_pixel_binarizer.sv
// Binarizes a byte-wide pixel stream against a threshold and assembles one
// NUM_PIXELS-bit vector per frame, double-buffered behind a valid/ready output.
module mnist_pixel_binarizer #(
  parameter int unsigned NUM_PIXELS = 784,
  parameter int unsigned PIXEL_W    = 8,
  parameter int unsigned THRESH     = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PIXEL_W-1:0]    s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [NUM_PIXELS-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  err_len
);

  localparam int unsigned        IdxW      = $clog2(NUM_PIXELS);
  localparam logic [IdxW-1:0]    LastIdx   = IdxW'(NUM_PIXELS - 1);
  localparam logic [PIXEL_W-1:0] ThreshVal = PIXEL_W'(THRESH);

  typedef enum logic [1:0] {StCollect, StXfer, StDrop} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [NUM_PIXELS-1:0] buf_q, buf_d;
  logic [NUM_PIXELS-1:0] m_data_q, m_data_d;
  logic                  m_valid_q, m_valid_d;
  logic                  err_q, err_d;
  logic                  drop_q, drop_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q && !m_ready;
    err_d     = 1'b0;
    drop_d    = drop_q;
    s_ready   = 1'b0;

    unique case (state_q)
      StCollect: begin
        s_ready = 1'b1;
        if (s_valid) begin
          buf_d[idx_q] = (s_data >= ThreshVal);
          if (idx_q == LastIdx) begin
            // A full frame without last still ships; the overrun tail is dropped.
            state_d = StXfer;
            drop_d  = !s_last;
            err_d   = !s_last;
          end else if (s_last) begin
            err_d = 1'b1;
            idx_d = '0;
            buf_d = '0;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StXfer: begin
        if (!m_valid_q || m_ready) begin
          m_data_d  = buf_q;
          m_valid_d = 1'b1;
          idx_d     = '0;
          buf_d     = '0;
          drop_d    = 1'b0;
          state_d   = drop_q ? StDrop : StCollect;
        end
      end
      StDrop: begin
        s_ready = 1'b1;
        if (s_valid && s_last) begin
          state_d = StCollect;
          idx_d   = '0;
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StCollect;
      idx_q     <= '0;
      buf_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      err_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      buf_q     <= buf_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      err_q     <= err_d;
      drop_q    <= drop_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign err_len = err_q;

endmodule

// File: doc/mnist_pixel_binarizer.md
Name: mnist_pixel_binarizer

Overview:
- Upstream feeder for the first neuron layer (ens0_layer0 neuron LUTs). Accepts a byte-wide pixel stream with valid/ready and per-frame last, and binarizes each pixel against a threshold.
- Assembles one NUM_PIXELS-bit input vector per image and presents it, registered, with a valid/ready handshake to the layer-0 LUT array. Each layer-0 neuron taps its 8-bit fan-in slice from that vector.
- Double-buffered: the next frame is collected while the previous vector is held for the consumer.

Parameters:
- NUM_PIXELS, 784, pixels per frame = width of output vector.
- PIXEL_W, 8, input pixel width.
- THRESH, 128, binarization threshold; output bit = (pixel >= THRESH), unsigned compare.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  reset: one clock; reset is synchronous and active-low.
- s_data  in  PIXEL_W  pixel value, unsigned.
- s_valid  in  1  pixel beat valid.
- s_last  in  1  marks final pixel of frame.
- s_ready  out  1  block accepts beat when s_valid && s_ready.
- m_data  out  NUM_PIXELS  binarized image, pixel k -> bit k (pixel 0 = first beat).
- m_valid  out  1  m_data holds a complete frame.
- m_ready  in  1  consumer accepts on m_valid && m_ready.
- err_len  out  1  one-cycle pulse on frame-length error.

Behaviour:
- Reset (rst=0 at clk edge): collect index idx=0, collect buffer=0, m_data=0, m_valid=0, err_len=0, state=COLLECT. Reset overrides any in-progress frame or held output.
- State COLLECT: s_ready=1. On accepted beat: buf[idx] <= (s_data >= THRESH); idx++.
  - Beat with idx==NUM_PIXELS-1 and s_last=1: frame complete; go to XFER.
  - Beat with idx==NUM_PIXELS-1 and s_last=0: frame complete, err_len pulses next cycle; go to XFER, then DROP.
  - Beat with s_last=1 and idx<NUM_PIXELS-1: early last. Pulse err_len next cycle, discard the partial frame (idx<=0, buf<=0), stay in COLLECT. No output is produced.
- State XFER: s_ready=0.
  - If m_valid==0, or m_valid && m_ready this cycle: m_data <= complete buffer (final beat included), m_valid <= 1, idx <= 0, buf <= 0.
  - Then go to COLLECT, or to DROP if flagged.
  - Otherwise hold in XFER (stall); the buffer is unchanged.
- State DROP: s_ready=1. Accepted beats are discarded. The beat with s_last=1 returns to COLLECT with idx=0. No further err_len pulse.
- Output: m_valid clears on m_valid && m_ready unless XFER loads the same cycle, in which case it stays 1 with new data. m_data is stable while m_valid && !m_ready.
- Latency: final accepted beat at cycle t -> XFER at t+1 -> m_valid=1 at t+2 when the output register is free.
- Throughput: one pixel/cycle sustained. One bubble cycle (s_ready=0 in XFER) per frame. No loss if the consumer drains within NUM_PIXELS cycles.
- s_ready is a function of state only, never of s_valid (no combinational path s_valid->s_ready). m_ready does not combinationally drive s_ready.
- err_len is registered, exactly one cycle wide per error event.

Test Plan:
- Reset, then 784 beats s_data=0xFF with s_last on beat 784, m_ready=1 -> m_valid=1 two cycles after the last beat, m_data all ones, err_len never 1.
- Threshold edge: pixel k = 127 for even k, 128 for odd k -> m_data = 0xAAAA...A (bit k = k odd); then value 0 and 255 at pixels 0 and 783 checked at bits 0 and 783.
- Back-pressure: m_ready=0, send two full frames (A all ones, B alternating 0x00/0xFF) -> after B's last beat, s_ready=0 and m_data stays A. Raise m_ready for 1 cycle -> m_data=B next cycle, s_ready=1.
- Early last: s_last on beat 10 -> err_len pulse once, no m_valid. Next 784-beat frame of 0xC0 yields all ones.
- Late last: 790 beats, s_last on beat 790 -> frame of first 784 pixels output, one err_len pulse, beats 785-790 dropped. Next frame aligned at bit 0.
- Reset mid-frame: rst=0 for 1 cycle after beat 400 with m_valid=1 held -> m_valid=0, m_data=0, idx=0. Next full frame is output correctly.
